// File: rtl/alien_hit_detect.sv
`default_nettype none
// ============================================================================
// Module   : alien_hit_detect
// Brief    : Once-per-frame laser/alien collision stage. Samples the laser
//            position at frame start, maps it onto the formation grid,
//            clears the struck alien, signals hit_alien back to the laser
//            and accumulates a saturating score.
// Options  : ALIEN_EXPLOSION_EN - when defined, holds an explosion marker
//            (row/col) for EXPLOSION_FRAMES frame starts after each hit.
// Revision : 1.0 - initial release
// ============================================================================
module alien_hit_detect #(
    parameter int ROWS             = 5,
    parameter int COLS             = 11,
    parameter int CELL_W_LOG2      = 6,
    parameter int CELL_H_LOG2      = 5,
    parameter int ALIEN_W          = 48,
    parameter int ALIEN_H          = 32,
    parameter int EXPLOSION_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vsync,
    input  logic                 new_wave,
    input  logic                 laser_active,
    input  logic [9:0]           laser_x,
    input  logic [9:0]           laser_y,
    input  logic [9:0]           grid_x,
    input  logic [9:0]           grid_y,
    output logic                 hit_alien,
    output logic [ROWS*COLS-1:0] alive,
    output logic                 all_dead,
    output logic [15:0]          score,
    output logic                 expl_active,
    output logic [2:0]           expl_row,
    output logic [3:0]           expl_col
);

    localparam int NB = ROWS * COLS;
    // Column/row fields of a non-negative 10-bit offset.
    localparam int CW = 10 - CELL_W_LOG2;
    localparam int RW = 10 - CELL_H_LOG2;
    localparam logic [2:0] EXPL_LOAD = 3'(EXPLOSION_FRAMES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_MAP    = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    logic                   vsync_q;
    logic                   frame_start;
    logic [2:0]             state_q, state_d;

    logic                   lat_active_q, lat_active_d;
    logic [9:0]             lat_lx_q, lat_lx_d;
    logic [9:0]             lat_ly_q, lat_ly_d;
    logic [9:0]             lat_gx_q, lat_gx_d;
    logic [9:0]             lat_gy_q, lat_gy_d;

    logic                   dx_neg_q, dx_neg_d;
    logic                   dy_neg_q, dy_neg_d;
    logic [CW-1:0]          col_q, col_d;
    logic [RW-1:0]          row_q, row_d;
    logic [CELL_W_LOG2-1:0] ox_q, ox_d;
    logic [CELL_H_LOG2-1:0] oy_q, oy_d;

    logic                   cand_q, cand_d;
    logic [NB-1:0]          sel_q, sel_d;

    logic                   hit_q, hit_d;
    logic [NB-1:0]          alive_q, alive_d;
    logic [15:0]            score_q, score_d;
    logic                   all_dead_q, all_dead_d;

    logic [10:0]            dx;
    logic [10:0]            dy;
    logic [NB-1:0]          sel_w;
    logic                   in_range;
    logic                   in_body;
    logic [5:0]             points;
    logic [16:0]            score_sum;
    logic                   hit_event;

    assign frame_start = vsync & ~vsync_q;

    // Signed 11-bit offsets of the laser from the formation origin.
    assign dx = {1'b0, lat_lx_q} - {1'b0, lat_gx_q};
    assign dy = {1'b0, lat_ly_q} - {1'b0, lat_gy_q};

    // One-hot select of the alive bit addressed by the mapped row/col.
    for (genvar gi = 0; gi < NB; gi++) begin : g_sel
        assign sel_w[gi] = (32'(row_q) == 32'(gi / COLS)) &&
                           (32'(col_q) == 32'(gi % COLS));
    end

    assign in_range = (32'(col_q) < 32'(COLS)) && (32'(row_q) < 32'(ROWS));
    assign in_body  = (32'(ox_q) < 32'(ALIEN_W)) && (32'(oy_q) < 32'(ALIEN_H));

    // Top row is worth most, the two middle rows next, the rest least.
    assign points    = (row_q == '0) ? 6'd30 :
                       (32'(row_q) <= 32'd2) ? 6'd20 : 6'd10;
    assign score_sum = {1'b0, score_q} + {11'd0, points};
    assign hit_event = (state_q == S_UPDATE) && cand_q;

    // Next-state logic for the frame FSM, latches, mapping and results.
    always_comb begin
        state_d      = state_q;
        lat_active_d = lat_active_q;
        lat_lx_d     = lat_lx_q;
        lat_ly_d     = lat_ly_q;
        lat_gx_d     = lat_gx_q;
        lat_gy_d     = lat_gy_q;
        dx_neg_d     = dx_neg_q;
        dy_neg_d     = dy_neg_q;
        col_d        = col_q;
        row_d        = row_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        cand_d       = cand_q;
        sel_d        = sel_q;
        hit_d        = hit_q;
        alive_d      = alive_q;
        score_d      = score_q;
        all_dead_d   = ~|alive_q;

        case (state_q)
            S_IDLE: begin
                // hit_alien is held until here so the laser sees it on vsync.
                if (frame_start) begin
                    state_d = S_LATCH;
                    hit_d   = 1'b0;
                end
            end
            S_LATCH: begin
                lat_active_d = laser_active;
                lat_lx_d     = laser_x;
                lat_ly_d     = laser_y;
                lat_gx_d     = grid_x;
                lat_gy_d     = grid_y;
                state_d      = S_MAP;
            end
            S_MAP: begin
                dx_neg_d = dx[10];
                dy_neg_d = dy[10];
                col_d    = dx[9:CELL_W_LOG2];
                row_d    = dy[9:CELL_H_LOG2];
                ox_d     = dx[CELL_W_LOG2-1:0];
                oy_d     = dy[CELL_H_LOG2-1:0];
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                cand_d  = lat_active_q && !dx_neg_q && !dy_neg_q &&
                          in_range && in_body && (|(alive_q & sel_w));
                sel_d   = sel_w;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (cand_q) begin
                    alive_d = alive_q & ~sel_q;
                    hit_d   = 1'b1;
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new wave overrides any clear performed in the same cycle.
        if (new_wave) begin
            alive_d = '1;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q      <= 1'b0;
            state_q      <= S_IDLE;
            lat_active_q <= 1'b0;
            lat_lx_q     <= '0;
            lat_ly_q     <= '0;
            lat_gx_q     <= '0;
            lat_gy_q     <= '0;
            dx_neg_q     <= 1'b0;
            dy_neg_q     <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            cand_q       <= 1'b0;
            sel_q        <= '0;
            hit_q        <= 1'b0;
            alive_q      <= '1;
            score_q      <= '0;
            all_dead_q   <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            state_q      <= state_d;
            lat_active_q <= lat_active_d;
            lat_lx_q     <= lat_lx_d;
            lat_ly_q     <= lat_ly_d;
            lat_gx_q     <= lat_gx_d;
            lat_gy_q     <= lat_gy_d;
            dx_neg_q     <= dx_neg_d;
            dy_neg_q     <= dy_neg_d;
            col_q        <= col_d;
            row_q        <= row_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            cand_q       <= cand_d;
            sel_q        <= sel_d;
            hit_q        <= hit_d;
            alive_q      <= alive_d;
            score_q      <= score_d;
            all_dead_q   <= all_dead_d;
        end
    end

    assign hit_alien = hit_q;
    assign alive     = alive_q;
    assign all_dead  = all_dead_q;
    assign score     = score_q;

`ifdef ALIEN_EXPLOSION_EN
    logic       expl_active_q, expl_active_d;
    logic [2:0] expl_row_q, expl_row_d;
    logic [3:0] expl_col_q, expl_col_d;
    logic [2:0] expl_cnt_q, expl_cnt_d;

    // Explosion marker: loaded on a hit, aged by one per frame start.
    always_comb begin
        expl_active_d = expl_active_q;
        expl_row_d    = expl_row_q;
        expl_col_d    = expl_col_q;
        expl_cnt_d    = expl_cnt_q;
        if (frame_start && expl_active_q) begin
            if (expl_cnt_q == 3'd0) begin
                expl_active_d = 1'b0;
            end else begin
                expl_cnt_d = expl_cnt_q - 3'd1;
            end
        end
        if (hit_event) begin
            expl_active_d = 1'b1;
            expl_row_d    = 3'(row_q);
            expl_col_d    = 4'(col_q);
            expl_cnt_d    = EXPL_LOAD;
        end
        if (new_wave) begin
            expl_active_d = 1'b0;
        end
    end

    // Explosion marker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expl_active_q <= 1'b0;
            expl_row_q    <= '0;
            expl_col_q    <= '0;
            expl_cnt_q    <= '0;
        end else begin
            expl_active_q <= expl_active_d;
            expl_row_q    <= expl_row_d;
            expl_col_q    <= expl_col_d;
            expl_cnt_q    <= expl_cnt_d;
        end
    end

    assign expl_active = expl_active_q;
    assign expl_row    = expl_row_q;
    assign expl_col    = expl_col_q;
`else
    logic unused_expl_cfg;
    assign unused_expl_cfg = ^{EXPL_LOAD, hit_event};
    assign expl_active     = 1'b0;
    assign expl_row        = 3'd0;
    assign expl_col        = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alien_hit_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_alien_hit_detect
// Brief    : Scoreboard bench for alien_hit_detect. A behavioural model
//            predicts each frame's outcome when the frame is driven; the
//            prediction is popped and compared once the DUT updates.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alien_hit_detect;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        new_wave;
    logic        laser_active;
    logic [9:0]  laser_x;
    logic [9:0]  laser_y;
    logic [9:0]  grid_x;
    logic [9:0]  grid_y;
    logic        hit_alien;
    logic [54:0] alive;
    logic        all_dead;
    logic [15:0] score;
    logic        expl_active;
    logic [2:0]  expl_row;
    logic [3:0]  expl_col;

    typedef struct {
        logic        hit;
        logic [54:0] alive;
        logic [15:0] score;
    } exp_t;

    exp_t        sb[$];
    logic [54:0] alive_m;
    int          score_m;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    alien_hit_detect dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .new_wave     (new_wave),
        .laser_active (laser_active),
        .laser_x      (laser_x),
        .laser_y      (laser_y),
        .grid_x       (grid_x),
        .grid_y       (grid_y),
        .hit_alien    (hit_alien),
        .alive        (alive),
        .all_dead     (all_dead),
        .score        (score),
        .expl_active  (expl_active),
        .expl_row     (expl_row),
        .expl_col     (expl_col)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; the model's prediction goes on the scoreboard and is
    // compared right after the fourth edge following frame start.
    task automatic run_frame(input bit act, input int lx, input int ly, input bit nw);
        exp_t        e;
        int          dx, dy, r, c, pts, prev_score;
        bit          h;
        logic [54:0] prev_alive;
        prev_score = score_m;
        prev_alive = alive_m;
        dx = lx - int'(grid_x);
        dy = ly - int'(grid_y);
        h  = act && dx >= 0 && dy >= 0 && (dx / 64) < 11 && (dy / 32) < 5 &&
             (dx % 64) < 48 && (dy % 32) < 32;
        if (h) begin
            r = dy / 32;
            c = dx / 64;
            h = alive_m[r * 11 + c];
            if (h) begin
                alive_m[r * 11 + c] = 1'b0;
                pts = (r == 0) ? 30 : (r <= 2) ? 20 : 10;
                score_m = score_m + pts;
                if (score_m > 65535) score_m = 65535;
            end
        end
        if (nw) alive_m = '1;
        e.hit   = h;
        e.alive = alive_m;
        e.score = score_m[15:0];
        sb.push_back(e);

        laser_active = act;
        laser_x      = lx[9:0];
        laser_y      = ly[9:0];
        vsync        = 1'b1;
        tick(1);
        vsync = 1'b0;
        check("hit_clear_at_frame_start", {63'd0, hit_alien}, 64'd0);
        tick(3);
        check("hit_before_update", {63'd0, hit_alien}, 64'd0);
        check("score_before_update", {48'd0, score}, 64'(prev_score));
        check("alive_before_update", {9'd0, alive}, {9'd0, prev_alive});
        if (nw) new_wave = 1'b1;
        tick(1);
        new_wave = 1'b0;
        e = sb.pop_front();
        check("hit_alien", {63'd0, hit_alien}, {63'd0, e.hit});
        check("alive", {9'd0, alive}, {9'd0, e.alive});
        check("score", {48'd0, score}, {48'd0, e.score});
        tick(1);
        check("all_dead", {63'd0, all_dead}, {63'd0, (alive_m == 55'd0)});
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        vsync        = 1'b0;
        new_wave     = 1'b0;
        laser_active = 1'b0;
        laser_x      = '0;
        laser_y      = '0;
        grid_x       = 10'd100;
        grid_y       = 10'd120;
        alive_m      = '1;
        score_m      = 0;
        tick(2);
        check("rst_alive", {9'd0, alive}, {9'd0, {55{1'b1}}});
        check("rst_score", {48'd0, score}, 64'd0);
        check("rst_hit", {63'd0, hit_alien}, 64'd0);
        check("rst_all_dead", {63'd0, all_dead}, 64'd0);
        check("rst_expl", {56'd0, expl_active, expl_row, expl_col}, 64'd0);
        reset = 1'b0;
        tick(2);

        // Formation hit on row 0, col 0, then the laser retires.
        run_frame(1'b1, 110, 125, 1'b0);
        run_frame(1'b0, 110, 125, 1'b0);

        // Row 3, col 10 hit, then a miss in the gap of the same cell.
        run_frame(1'b1, 744, 218, 1'b0);
        check("bit43_cleared", {63'd0, alive[43]}, 64'd0);
        run_frame(1'b1, 790, 218, 1'b0);

        // Dead alien, left of grid, above grid, right of grid.
        run_frame(1'b1, 110, 125, 1'b0);
        run_frame(1'b1, 99, 125, 1'b0);
        run_frame(1'b1, 110, 119, 1'b0);
        run_frame(1'b1, 806, 125, 1'b0);
        // Row 5 is below the formation.
        run_frame(1'b1, 110, 120 + 160 + 1, 1'b0);

        // Clear every alien in the formation.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 11; c++) begin
                run_frame(1'b1, 100 + c * 64 + 5, 120 + r * 32 + 3, 1'b0);
            end
        end
        check("all_dead_set", {63'd0, all_dead}, 64'd1);

        // Standalone new wave, then a hit with new_wave coinciding with UPDATE.
        new_wave = 1'b1;
        tick(1);
        new_wave = 1'b0;
        alive_m  = '1;
        check("new_wave_alive", {9'd0, alive}, {9'd0, {55{1'b1}}});
        tick(1);
        check("new_wave_all_dead", {63'd0, all_dead}, 64'd0);
        run_frame(1'b1, 110, 125, 1'b1);

        // Reset asserted while the FSM is in MAP.
        laser_active = 1'b1;
        laser_x      = 10'd200;
        laser_y      = 10'd160;
        vsync        = 1'b1;
        tick(1);
        vsync = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        check("midrst_alive", {9'd0, alive}, {9'd0, {55{1'b1}}});
        check("midrst_score", {48'd0, score}, 64'd0);
        check("midrst_hit", {63'd0, hit_alien}, 64'd0);
        tick(1);
        reset   = 1'b0;
        alive_m = '1;
        score_m = 0;
        tick(1);
        // FSM must be back in IDLE and accept a fresh frame.
        run_frame(1'b1, 100 + 3 * 64 + 1, 120 + 2 * 32 + 1, 1'b0);

`ifdef ALIEN_EXPLOSION_EN
        check("expl_active_on_hit", {63'd0, expl_active}, 64'd1);
        check("expl_row", {61'd0, expl_row}, 64'd2);
        check("expl_col", {60'd0, expl_col}, 64'd3);
        for (int k = 1; k <= 8; k++) begin
            run_frame(1'b0, 0, 0, 1'b0);
            check("expl_active_age", {63'd0, expl_active}, {63'd0, (k < 8)});
        end
`else
        check("expl_tied_off", {56'd0, expl_active, expl_row, expl_col}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
